// File: rtl/cache_ctrl.sv
// Sequencing controller for a 2-way write-back cache: probe, victim write-back, refill,
// one update strobe per request, CPU completion pulse, memory watchdog and saturating stats.
module cache_ctrl #(
   parameter int unsigned TIMEOUT = 15,
   parameter int unsigned CNT_W   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cpu_req,
   input  logic             cpu_rwb,
   input  logic [5:0]       cpu_adr,
   input  logic [7:0]       cpu_wdata,
   output logic             cpu_ready,
   output logic             cpu_err,
   output logic [7:0]       cpu_rdata,
   output logic [5:0]       cache_adr,
   output logic             cache_rwb,
   output logic [7:0]       cache_wdata,
   output logic [7:0]       cache_fill,
   output logic             cache_update,
   input  logic             cache_hit,
   input  logic [7:0]       cache_rdata,
   input  logic             cache_vdirty,
   input  logic [5:0]       cache_vadr,
   input  logic [7:0]       cache_vdata,
   output logic             mem_req,
   output logic             mem_we,
   output logic [5:0]       mem_adr,
   output logic [7:0]       mem_wdata,
   input  logic [7:0]       mem_rdata,
   input  logic             mem_ack,
   output logic [CNT_W-1:0] hit_cnt,
   output logic [CNT_W-1:0] miss_cnt,
   output logic [CNT_W-1:0] wb_cnt
);

   typedef enum logic [2:0] {
      StIdle, StLookup, StWback, StFill, StUpdate, StDone, StErr
   } state_e;

   localparam logic [7:0]       WdLast = 8'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CntMax = '1;

   state_e           state_q, state_d;
   logic             rwb_q;
   logic [5:0]       adr_q, vadr_q;
   logic [7:0]       wdata_q, vdata_q, fill_q, result_q;
   logic [7:0]       wd_q;
   logic [CNT_W-1:0] hit_q, miss_q, wb_q;

   assign cache_adr   = adr_q;
   assign cache_rwb   = rwb_q;
   assign cache_wdata = wdata_q;
   assign cache_fill  = fill_q;
   assign hit_cnt     = hit_q;
   assign miss_cnt    = miss_q;
   assign wb_cnt      = wb_q;

   always_comb begin
      state_d      = state_q;
      cache_update = 1'b0;
      cpu_ready    = 1'b0;
      cpu_err      = 1'b0;
      cpu_rdata    = '0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_adr      = '0;
      mem_wdata    = '0;
      unique case (state_q)
         StIdle: begin
            if (cpu_req) state_d = StLookup;
         end
         StLookup: begin
            if (cache_hit) begin
               cache_update = 1'b1;
               state_d      = StDone;
            end else if (cache_vdirty) begin
               state_d = StWback;
            end else begin
               state_d = rwb_q ? StFill : StUpdate;
            end
         end
         StWback: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_adr   = vadr_q;
            mem_wdata = vdata_q;
            // An ack on the final watchdog cycle still completes normally.
            if (mem_ack)             state_d = rwb_q ? StFill : StUpdate;
            else if (wd_q == WdLast) state_d = StErr;
         end
         StFill: begin
            mem_req = 1'b1;
            mem_adr = adr_q;
            if (mem_ack)             state_d = StUpdate;
            else if (wd_q == WdLast) state_d = StErr;
         end
         StUpdate: begin
            cache_update = 1'b1;
            state_d      = StDone;
         end
         StDone: begin
            cpu_ready = 1'b1;
            cpu_rdata = rwb_q ? result_q : '0;
            state_d   = StIdle;
         end
         StErr: begin
            cpu_ready = 1'b1;
            cpu_err   = 1'b1;
            state_d   = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= StIdle;
         rwb_q    <= 1'b0;
         adr_q    <= '0;
         wdata_q  <= '0;
         vadr_q   <= '0;
         vdata_q  <= '0;
         fill_q   <= '0;
         result_q <= '0;
         wd_q     <= '0;
         hit_q    <= '0;
         miss_q   <= '0;
         wb_q     <= '0;
      end else begin
         state_q <= state_d;
         // Watchdog restarts on every state change, including WBACK -> FILL.
         if (state_d != state_q) wd_q <= '0;
         else if (mem_req)       wd_q <= wd_q + 8'd1;

         if (state_q == StIdle && cpu_req) begin
            rwb_q    <= cpu_rwb;
            adr_q    <= cpu_adr;
            wdata_q  <= cpu_wdata;
            fill_q   <= '0;
            result_q <= '0;
         end
         if (state_q == StLookup) begin
            if (cache_hit) begin
               result_q <= cache_rdata;
               if (hit_q != CntMax) hit_q <= hit_q + 1'b1;
            end else begin
               vadr_q  <= cache_vadr;
               vdata_q <= cache_vdata;
               if (miss_q != CntMax) miss_q <= miss_q + 1'b1;
            end
         end
         if (state_q == StWback && mem_ack && wb_q != CntMax) wb_q <= wb_q + 1'b1;
         if (state_q == StFill && mem_ack) fill_q <= mem_rdata;
         if (state_q == StUpdate && rwb_q) result_q <= fill_q;
      end
   end

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: scripted cache inputs, a delay-programmable memory
// responder, and a response scoreboard checked inline by each scenario task.
module tb_cache_ctrl;
   localparam int unsigned TIMEOUT = 4;
   localparam int unsigned CNT_W   = 8;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             cpu_req = 1'b0, cpu_rwb = 1'b0;
   logic [5:0]       cpu_adr = '0;
   logic [7:0]       cpu_wdata = '0;
   logic             cpu_ready, cpu_err;
   logic [7:0]       cpu_rdata;
   logic [5:0]       cache_adr;
   logic             cache_rwb;
   logic [7:0]       cache_wdata, cache_fill;
   logic             cache_update;
   logic             cache_hit = 1'b0, cache_vdirty = 1'b0;
   logic [7:0]       cache_rdata = '0, cache_vdata = '0;
   logic [5:0]       cache_vadr = '0;
   logic             mem_req, mem_we;
   logic [5:0]       mem_adr;
   logic [7:0]       mem_wdata;
   logic [7:0]       mem_rdata;
   logic             mem_ack, resp_ack, stray_ack = 1'b0;
   logic [CNT_W-1:0] hit_cnt, miss_cnt, wb_cnt;

   int n_cmp = 0, n_bad = 0;
   int exp_hit = 0, exp_miss = 0, exp_wb = 0;
   int upd_cnt = 0, req_cyc = 0, err_cyc = 0;
   int wb_delay = 0, rd_delay = 0;
   logic [7:0]  rd_data = '0;
   logic [8:0]  exp_q[$];   // {err, rdata}
   logic [9:0]  rsp_q[$];   // {missing, err, rdata}
   logic [14:0] mem_log[$]; // {we, adr, wdata} of each acknowledged transaction

   assign mem_ack = resp_ack | stray_ack;

   cache_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_rwb(cpu_rwb), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
      .cpu_ready(cpu_ready), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
      .cache_adr(cache_adr), .cache_rwb(cache_rwb), .cache_wdata(cache_wdata),
      .cache_fill(cache_fill), .cache_update(cache_update), .cache_hit(cache_hit),
      .cache_rdata(cache_rdata), .cache_vdirty(cache_vdirty), .cache_vadr(cache_vadr),
      .cache_vdata(cache_vdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
   );

   initial forever #5 clk = ~clk;

   // Memory responder: acks on the (delay+1)-th cycle of each request.
   initial begin
      int w;
      w = 0;
      resp_ack = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         resp_ack = 1'b0;
         if (!mem_req) begin
            w = 0;
         end else if (w >= (mem_we ? wb_delay : rd_delay)) begin
            resp_ack = 1'b1;
            mem_rdata = rd_data;
            mem_log.push_back({mem_we, mem_adr, mem_wdata});
            w = 0;
         end else begin
            w++;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (cache_update) upd_cnt++;
      if (mem_req) req_cyc++;
      if (cpu_err) err_cyc++;
      if (cpu_ready) rsp_q.push_back({1'b0, cpu_err, cpu_rdata});
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running, required finish");
      $fatal(1, "timeout");
   end

   function automatic logic [9:0] pop_rsp();
      if (rsp_q.size() == 0) return 10'h3FF;
      return rsp_q.pop_front();
   endfunction

   function automatic logic [9:0] pop_exp();
      if (exp_q.size() == 0) return 10'h3FE;
      return {1'b0, exp_q.pop_front()};
   endfunction

   function automatic logic [14:0] log_at(input int i);
      if (mem_log.size() <= i) return 15'h7FFF;
      return mem_log[i];
   endfunction

   function automatic int sat_inc(input int v);
      return (v >= 255) ? 255 : v + 1;
   endfunction

   // Drives one request and measures cpu_ready latency in cycles (0 = never came).
   task automatic issue(input logic rwb, input logic [5:0] adr, input logic [7:0] wd,
                        output int lat);
      @(negedge clk);
      cpu_req = 1'b1; cpu_rwb = rwb; cpu_adr = adr; cpu_wdata = wd;
      lat = 0;
      for (int c = 1; c <= 400; c++) begin
         @(negedge clk);
         if (c == 1) begin
            cpu_req = 1'b0; cpu_rwb = ~rwb; cpu_adr = ~adr; cpu_wdata = ~wd;
         end
         if (cpu_ready) begin
            lat = c;
            break;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_cmp++; if ({cpu_ready, cpu_err, cache_update, mem_req} !== 4'b0) begin
         n_bad++; $display("FAIL reset_ctrl: got %b want 0000",
                           {cpu_ready, cpu_err, cache_update, mem_req});
      end
      n_cmp++; if ({hit_cnt, miss_cnt, wb_cnt} !== 24'h0) begin
         n_bad++; $display("FAIL reset_cnt: got %h want 0", {hit_cnt, miss_cnt, wb_cnt});
      end
      n_cmp++; if ({cache_adr, cache_wdata, cache_fill, cpu_rdata} !== 30'h0) begin
         n_bad++; $display("FAIL reset_data: got %h want 0",
                           {cache_adr, cache_wdata, cache_fill, cpu_rdata});
      end
      reset = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++; if ({cpu_ready, cache_update, mem_req} !== 3'b0) begin
         n_bad++; $display("FAIL idle_quiet: got %b want 000", {cpu_ready, cache_update, mem_req});
      end
   endtask

   task automatic test_write_read();
      int lat, u0, r0;
      logic [9:0] got, exp;
      cache_hit = 1'b0; cache_vdirty = 1'b0;
      u0 = upd_cnt; r0 = req_cyc;
      exp_q.push_back(9'h000); exp_miss++;
      issue(1'b0, 6'h0B, 8'h5A, lat);
      got = pop_rsp(); exp = pop_exp();
      n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL wr_rsp: got %h want %h", got, exp); end
      n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL wr_lat: got %0d want 3", lat); end
      n_cmp++; if (upd_cnt - u0 !== 1) begin
         n_bad++; $display("FAIL wr_upd: got %0d want 1", upd_cnt - u0);
      end
      n_cmp++; if (req_cyc - r0 !== 0) begin
         n_bad++; $display("FAIL wr_memreq: got %0d want 0", req_cyc - r0);
      end
      n_cmp++; if ({cache_adr, cache_rwb, cache_wdata} !== {6'h0B, 1'b0, 8'h5A}) begin
         n_bad++; $display("FAIL wr_cache_bus: got %h want %h",
                           {cache_adr, cache_rwb, cache_wdata}, {6'h0B, 1'b0, 8'h5A});
      end
      cache_hit = 1'b1; cache_rdata = 8'h5A;
      u0 = upd_cnt;
      exp_q.push_back(9'h05A); exp_hit++;
      issue(1'b1, 6'h0B, 8'h00, lat);
      got = pop_rsp(); exp = pop_exp();
      n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL rd_hit_rsp: got %h want %h", got, exp); end
      n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL rd_hit_lat: got %0d want 2", lat); end
      n_cmp++; if (upd_cnt - u0 !== 1) begin
         n_bad++; $display("FAIL rd_hit_upd: got %0d want 1", upd_cnt - u0);
      end
      n_cmp++; if ({32'(hit_cnt), 32'(miss_cnt)} !== {32'(exp_hit), 32'(exp_miss)}) begin
         n_bad++; $display("FAIL rd_hit_cnt: got %0d/%0d want %0d/%0d",
                           hit_cnt, miss_cnt, exp_hit, exp_miss);
      end
   endtask

   task automatic test_clean_miss();
      int lat, u0, r0;
      logic [9:0] got, exp;
      cache_hit = 1'b0; cache_vdirty = 1'b0; rd_delay = 3; rd_data = 8'hC3;
      mem_log.delete(); u0 = upd_cnt; r0 = req_cyc;
      exp_q.push_back(9'h0C3); exp_miss++;
      issue(1'b1, 6'h13, 8'h00, lat);
      got = pop_rsp(); exp = pop_exp();
      n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL cm_rsp: got %h want %h", got, exp); end
      n_cmp++; if (lat !== 7) begin n_bad++; $display("FAIL cm_lat: got %0d want 7", lat); end
      n_cmp++; if (mem_log.size() !== 1 || log_at(0) !== {1'b0, 6'h13, 8'h00}) begin
         n_bad++; $display("FAIL cm_memtxn: got n=%0d %h want n=1 %h",
                           mem_log.size(), log_at(0), {1'b0, 6'h13, 8'h00});
      end
      n_cmp++; if (req_cyc - r0 !== 4) begin
         n_bad++; $display("FAIL cm_reqcyc: got %0d want 4", req_cyc - r0);
      end
      n_cmp++; if (upd_cnt - u0 !== 1) begin
         n_bad++; $display("FAIL cm_upd: got %0d want 1", upd_cnt - u0);
      end
      n_cmp++; if (cache_fill !== 8'hC3) begin
         n_bad++; $display("FAIL cm_fill: got %h want c3", cache_fill);
      end
      n_cmp++; if (32'(miss_cnt) !== exp_miss) begin
         n_bad++; $display("FAIL cm_miss_cnt: got %0d want %0d", miss_cnt, exp_miss);
      end
   endtask

   task automatic test_dirty_miss();
      int lat, u0;
      logic [9:0] got, exp;
      cache_hit = 1'b0; cache_vdirty = 1'b1; cache_vadr = 6'h23; cache_vdata = 8'h77;
      wb_delay = 1; rd_delay = 2; rd_data = 8'h9E;
      mem_log.delete(); u0 = upd_cnt;
      exp_q.push_back(9'h09E); exp_miss++; exp_wb++;
      issue(1'b1, 6'h05, 8'h00, lat);
      got = pop_rsp(); exp = pop_exp();
      n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL dm_rsp: got %h want %h", got, exp); end
      n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL dm_lat: got %0d want 8", lat); end
      n_cmp++; if (mem_log.size() !== 2 || log_at(0) !== {1'b1, 6'h23, 8'h77}
                   || log_at(1) !== {1'b0, 6'h05, 8'h00}) begin
         n_bad++; $display("FAIL dm_memtxn: got n=%0d %h %h want n=2 %h %h", mem_log.size(),
                           log_at(0), log_at(1), {1'b1, 6'h23, 8'h77}, {1'b0, 6'h05, 8'h00});
      end
      n_cmp++; if (upd_cnt - u0 !== 1) begin
         n_bad++; $display("FAIL dm_upd: got %0d want 1", upd_cnt - u0);
      end
      n_cmp++; if (32'(wb_cnt) !== exp_wb) begin
         n_bad++; $display("FAIL dm_wb_cnt: got %0d want %0d", wb_cnt, exp_wb);
      end
      // Dirty write miss: write-back then straight to update, no refill.
      wb_delay = 0; mem_log.delete(); u0 = upd_cnt;
      exp_q.push_back(9'h000); exp_miss++; exp_wb++;
      issue(1'b0, 6'h2A, 8'h11, lat);
      got = pop_rsp(); exp = pop_exp();
      n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL dw_rsp: got %h want %h", got, exp); end
      n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL dw_lat: got %0d want 4", lat); end
      n_cmp++; if (mem_log.size() !== 1 || log_at(0) !== {1'b1, 6'h23, 8'h77}) begin
         n_bad++; $display("FAIL dw_memtxn: got n=%0d %h want n=1 %h",
                           mem_log.size(), log_at(0), {1'b1, 6'h23, 8'h77});
      end
      n_cmp++; if ({32'(wb_cnt), 32'(upd_cnt - u0)} !== {32'(exp_wb), 32'd1}) begin
         n_bad++; $display("FAIL dw_wb_upd: got wb=%0d upd=%0d want wb=%0d upd=1",
                           wb_cnt, upd_cnt - u0, exp_wb);
      end
   endtask

   task automatic test_timeout();
      int lat, u0, r0, e0;
      logic [9:0] got, exp;
      cache_hit = 1'b0; cache_vdirty = 1'b0; rd_delay = 255;
      u0 = upd_cnt; r0 = req_cyc; e0 = err_cyc;
      exp_q.push_back(9'h100); exp_miss++;
      issue(1'b1, 6'h31, 8'h00, lat);
      got = pop_rsp(); exp = pop_exp();
      n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL to_rsp: got %h want %h", got, exp); end
      n_cmp++; if (lat !== 6) begin n_bad++; $display("FAIL to_lat: got %0d want 6", lat); end
      n_cmp++; if ({32'(req_cyc - r0), 32'(upd_cnt - u0), 32'(err_cyc - e0)}
                   !== {32'd4, 32'd0, 32'd1}) begin
         n_bad++; $display("FAIL to_cycles: got req=%0d upd=%0d err=%0d want req=4 upd=0 err=1",
                           req_cyc - r0, upd_cnt - u0, err_cyc - e0);
      end
      cache_hit = 1'b1; cache_rdata = 8'h66;
      exp_q.push_back(9'h066); exp_hit++;
      issue(1'b1, 6'h3F, 8'h00, lat);
      got = pop_rsp(); exp = pop_exp();
      n_cmp++; if (got !== exp || lat !== 2) begin
         n_bad++; $display("FAIL to_next: got %h lat %0d want %h lat 2", got, lat, exp);
      end
      cache_hit = 1'b0; cache_vdirty = 1'b1; wb_delay = 255; u0 = upd_cnt;
      exp_q.push_back(9'h100); exp_miss++;
      issue(1'b1, 6'h32, 8'h00, lat);
      got = pop_rsp(); exp = pop_exp();
      n_cmp++; if (got !== exp || lat !== 6) begin
         n_bad++; $display("FAIL to_wb: got %h lat %0d want %h lat 6", got, lat, exp);
      end
      n_cmp++; if ({32'(wb_cnt), 32'(upd_cnt - u0)} !== {32'(exp_wb), 32'd0}) begin
         n_bad++; $display("FAIL to_wb_cnt: got wb=%0d upd=%0d want wb=%0d upd=0",
                           wb_cnt, upd_cnt - u0, exp_wb);
      end
      // Ack on the last watchdog cycle must complete normally.
      cache_vdirty = 1'b0; wb_delay = 0; rd_delay = 3; rd_data = 8'h4D;
      exp_q.push_back(9'h04D); exp_miss++;
      issue(1'b1, 6'h33, 8'h00, lat);
      got = pop_rsp(); exp = pop_exp();
      n_cmp++; if (got !== exp || lat !== 7) begin
         n_bad++; $display("FAIL to_edge_ack: got %h lat %0d want %h lat 7", got, lat, exp);
      end
   endtask

   task automatic test_reset_mid_fill();
      int lat, u0;
      logic seen;
      logic [9:0] got, exp;
      cache_hit = 1'b0; cache_vdirty = 1'b0; rd_delay = 255; u0 = upd_cnt;
      @(negedge clk);
      cpu_req = 1'b1; cpu_rwb = 1'b1; cpu_adr = 6'h15;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         cpu_req = 1'b0;
         seen = mem_req;
      end
      n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL rm_fill_seen: got 0 want 1"); end
      #2 reset = 1'b0;
      #1;
      n_cmp++; if ({mem_req, cpu_ready, cache_update} !== 3'b0) begin
         n_bad++; $display("FAIL rm_async: got %b want 000", {mem_req, cpu_ready, cache_update});
      end
      n_cmp++; if ({hit_cnt, miss_cnt, wb_cnt} !== 24'h0) begin
         n_bad++; $display("FAIL rm_cnt: got %h want 0", {hit_cnt, miss_cnt, wb_cnt});
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      exp_hit = 0; exp_miss = 0; exp_wb = 0;
      n_cmp++; if (upd_cnt - u0 !== 0 || rsp_q.size() !== 0) begin
         n_bad++; $display("FAIL rm_no_upd: got upd=%0d rsp=%0d want 0/0",
                           upd_cnt - u0, rsp_q.size());
      end
      cache_hit = 1'b1; cache_rdata = 8'hA5;
      exp_q.push_back(9'h0A5); exp_hit++;
      issue(1'b1, 6'h15, 8'h00, lat);
      got = pop_rsp(); exp = pop_exp();
      n_cmp++; if (got !== exp || lat !== 2) begin
         n_bad++; $display("FAIL rm_after: got %h lat %0d want %h lat 2", got, lat, exp);
      end
      n_cmp++; if ({32'(hit_cnt), 32'(miss_cnt)} !== {32'(exp_hit), 32'(exp_miss)}) begin
         n_bad++; $display("FAIL rm_after_cnt: got %0d/%0d want %0d/%0d",
                           hit_cnt, miss_cnt, exp_hit, exp_miss);
      end
   endtask

   task automatic test_saturation();
      int lat, u0, r0;
      logic [9:0] got, exp;
      logic [7:0] v;
      cache_hit = 1'b1; cache_vdirty = 1'b0;
      for (int i = 0; i < 256; i++) begin
         v = i[7:0];
         cache_rdata = v;
         exp_q.push_back({1'b0, v}); exp_hit = sat_inc(exp_hit);
         issue(1'b1, v[5:0], 8'h00, lat);
         got = pop_rsp(); exp = pop_exp();
         n_cmp++; if (got !== exp || lat !== 2) begin
            n_bad++; $display("FAIL sat_hit[%0d]: got %h lat %0d want %h lat 2", i, got, lat, exp);
         end
      end
      n_cmp++; if (32'(hit_cnt) !== exp_hit || hit_cnt !== 8'hFF) begin
         n_bad++; $display("FAIL sat_hold: got %0d want %0d", hit_cnt, exp_hit);
      end
      u0 = upd_cnt; r0 = req_cyc;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         stray_ack = k[0] ? 1'b0 : 1'b1;
      end
      @(negedge clk);
      stray_ack = 1'b0;
      #1;
      n_cmp++; if ({32'(upd_cnt - u0), 32'(req_cyc - r0), 32'(rsp_q.size())} !== 96'h0) begin
         n_bad++; $display("FAIL stray_quiet: got upd=%0d req=%0d rsp=%0d want 0/0/0",
                           upd_cnt - u0, req_cyc - r0, rsp_q.size());
      end
      n_cmp++; if ({32'(hit_cnt), 32'(miss_cnt), 32'(wb_cnt)}
                   !== {32'(exp_hit), 32'(exp_miss), 32'(exp_wb)}) begin
         n_bad++; $display("FAIL stray_cnt: got %0d/%0d/%0d want %0d/%0d/%0d",
                           hit_cnt, miss_cnt, wb_cnt, exp_hit, exp_miss, exp_wb);
      end
      cache_hit = 1'b0;
      exp_q.push_back(9'h000); exp_miss++;
      issue(1'b0, 6'h01, 8'h02, lat);
      got = pop_rsp(); exp = pop_exp();
      n_cmp++; if (got !== exp || lat !== 3) begin
         n_bad++; $display("FAIL stray_next: got %h lat %0d want %h lat 3", got, lat, exp);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_clean_miss();
      test_dirty_miss();
      test_timeout();
      test_reset_mid_fill();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Sequencing controller in front of the 2-way set-associative write-back cache (6-bit address, 8-bit data, 3-bit tag, 8 sets).
- Accepts one CPU request at a time and probes the cache.
- On a miss, writes back a dirty victim, then refills from a multi-cycle memory over a req/ack handshake.
- Issues exactly one cache update strobe per request and returns a ready pulse, with read data, to the CPU.
- Watchdog aborts hung memory transactions; saturating counters report hits, misses and write-backs.

Parameters:
- TIMEOUT, 15, max cycles a memory request waits for mem_ack before abort (1..255)
- CNT_W, 8, width of statistic counters

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  request valid, sampled only in IDLE
- cpu_rwb  in  1  1=read, 0=write
- cpu_adr  in  6  request address
- cpu_wdata  in  8  write data
- cpu_ready  out  1  one-cycle completion pulse
- cpu_err  out  1  one-cycle abort pulse, coincident with cpu_ready
- cpu_rdata  out  8  read result, valid while cpu_ready=1
- cache_adr  out  6  address presented to cache (latched request address)
- cache_rwb  out  1  operation presented to cache
- cache_wdata  out  8  write data to cache
- cache_fill  out  8  refill data to cache (memory data path)
- cache_update  out  1  one-cycle strobe; cache state may change only on this cycle
- cache_hit  in  1  cache hit indication
- cache_rdata  in  8  cache read data
- cache_vdirty  in  1  victim way dirty
- cache_vadr  in  6  victim write-back address
- cache_vdata  in  8  victim data
- mem_req  out  1  memory request
- mem_we  out  1  1=write-back, 0=refill read
- mem_adr  out  6  memory address
- mem_wdata  out  8  memory write data
- mem_rdata  in  8  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion, accepted when mem_req=1 and mem_ack=1 at a rising edge
- hit_cnt, miss_cnt, wb_cnt  out  CNT_W  saturating statistics

Behaviour:
- Reset (asynchronous, reset=0):
  - State goes to IDLE; all outputs and internal registers go to 0, counters included.
  - mem_req drops immediately, including mid-transaction.
  - No cache_update is issued for an interrupted request.
- States: IDLE, LOOKUP, WBACK, FILL, UPDATE, DONE, ERR.
- IDLE:
  - When cpu_req=1, latch cpu_rwb/cpu_adr/cpu_wdata into request registers and go to LOOKUP.
  - cpu_* inputs are ignored in all other states.
- LOOKUP (1 cycle): cache_adr/cache_rwb/cache_wdata are driven from the request registers throughout the transaction.
  - hit: cache_update=1, hit_cnt++, latch cache_rdata -> DONE.
  - miss: miss_cnt++, latch cache_vadr/cache_vdata.
    - If cache_vdirty=1 -> WBACK.
    - Else if read -> FILL.
    - Else -> UPDATE.
- WBACK:
  - mem_req=1, mem_we=1, mem_adr=latched vadr, mem_wdata=latched vdata.
  - On ack: wb_cnt++; read -> FILL, write -> UPDATE.
- FILL:
  - mem_req=1, mem_we=0, mem_adr=request address.
  - On ack: latch mem_rdata into fill register -> UPDATE.
- UPDATE (1 cycle):
  - cache_update=1, cache_fill=fill register.
  - For a read, the result register takes the fill value -> DONE.
- DONE (1 cycle): cpu_ready=1, cpu_rdata=result register (writes return 0) -> IDLE.
- Memory handshake:
  - mem_req and mem_adr/mem_we/mem_wdata remain stable until the ack edge.
  - mem_req deasserts in the cycle after the ack; WBACK->FILL therefore shows one mem_req=1 cycle with mem_we=1 and then a new request with mem_we=0.
  - mem_ack while mem_req=0 is ignored.
- Watchdog:
  - Counter clears on entry to WBACK/FILL and increments each cycle without ack.
  - When the count reaches TIMEOUT with no ack -> ERR.
  - ERR (1 cycle): cpu_ready=1, cpu_err=1, cpu_rdata=0, no cache_update -> IDLE.
  - An ack arriving on the TIMEOUT cycle wins (normal completion).
- Latency (edges counted from the edge that samples cpu_req in IDLE):
  - Hit: cpu_ready in cycle 2.
  - Clean read miss with ack after A cycles in FILL: cpu_ready in cycle 3+A+1.
  - Each write-back adds its own ack wait plus 1.
- Only one request is in flight at a time; a new request can be sampled in the cycle after DONE/ERR.
- Counters saturate at 2^CNT_W-1; there is no wrap-around.
- cache_update is never asserted outside LOOKUP-hit or UPDATE; exactly one strobe per non-aborted request.

Test Plan:
- After reset, write 0x5A to 0x0B (clean miss) then read 0x0B -> write: no mem_req, one cache_update; read: hit, cpu_rdata=0x5A in cycle 2, hit_cnt=1, miss_cnt=1.
- Read 0x13 (miss), cache_vdirty=0, mem acks after 3 cycles with 0xC3 -> single mem_req with mem_we=0 and mem_adr=0x13; cpu_rdata=0xC3; cpu_ready in cycle 7.
- Read miss with cache_vdirty=1, cache_vadr=0x23, cache_vdata=0x77 -> write-back (mem_we=1, mem_adr=0x23, mem_wdata=0x77) precedes refill of the request address; wb_cnt=1; exactly one cache_update.
- TIMEOUT=4, mem_ack held 0 -> ERR after 4 wait cycles, cpu_ready=cpu_err=1 for one cycle, no cache_update, next request accepted normally.
- Assert reset=0 while in FILL with mem_req=1 -> mem_req=0 immediately without waiting for clk; all counters 0; first request after release behaves as from power-up.
- Force 256 hits with CNT_W=8 -> hit_cnt holds 255; stray mem_ack pulses in IDLE cause no state change.
